// File: rtl/rda_iterative_adder.sv
// Multi-cycle recursive-doubling adder: one star-operator prefix round per clock.
// Define RDA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module rda_iterative_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RDA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int ROUNDS = $clog2(WIDTH) + 1;
  localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  localparam logic [1:0] K = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] G = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH:0][1:0] s;
  logic [WIDTH:0][1:0] s_enc;
  logic [WIDTH:0][1:0] s_rnd;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    c;
  logic [RW-1:0]       r;
  logic                last_rnd;

  assign last_rnd = (r == RW'(ROUNDS - 1));

  // Per-bit kill/propagate/generate from the raw operands
  always_comb begin
    s_enc    = '0;
    s_enc[0] = cin ? G : K;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i] & b[i])
        s_enc[i+1] = G;
      else if (~a[i] & ~b[i])
        s_enc[i+1] = K;
      else
        s_enc[i+1] = P;
    end
  end

  // One doubling round; reads only the pre-round vector
  always_comb begin
    int d;
    d     = 1 << r;
    s_rnd = s;
    for (int i = 1; i <= WIDTH; i++) begin
      if (i >= d && s[i] == P)
        s_rnd[i] = s[i-d];
    end
  end

  always_comb begin
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      c[i] = s[i][1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_rnd)
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      a_q  <= '0;
      b_q  <= '0;
      r    <= '0;
      sum  <= '0;
      cout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            s   <= s_enc;
            r   <= '0;
          end
        end
        RUN: begin
          s <= s_rnd;
          r <= r + RW'(1);
        end
        DONE: begin
          sum  <= a_q ^ b_q ^ c;
          cout <= s[WIDTH][1];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RDA_OVERFLOW_EN
  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf <= 1'b0;
    else if (state == DONE)
      ovf <= c[WIDTH-1] ^ s[WIDTH][1];
  end
`endif

endmodule

// File: tb/tb_rda_iterative_adder.sv
// Directed and random checks of rda_iterative_adder (WIDTH=8).
// Covers latency, handshake, ignored starts and mid-run reset.
module tb_rda_iterative_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef RDA_OVERFLOW_EN
  logic       ovf;
`endif

  int n_cmp;
  int n_bad;

  rda_iterative_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef RDA_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Issue one operation; returns at the negedge where done is seen.
  // b2b=1 means we are already at the negedge of the previous done.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                       input logic ci, input bit b2b);
    int lat;
    if (!b2b)
      @(negedge clk);
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom);
    check("busy_rise", {63'd0, busy}, 64'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd5);
  endtask

  initial begin
    logic [8:0] exp9;
    int         nd;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sum", {56'd0, sum}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    rst = 1'b0;

    do_op(8'h00, 8'h00, 1'b0, 1'b0);
    check("zero", {55'd0, cout, sum}, 64'h000);
    @(negedge clk);
    check("done_pulse", {63'd0, done}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);

    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    check("ripple_g", {55'd0, cout, sum}, 64'h100);
    do_op(8'hFF, 8'h00, 1'b1, 1'b0);
    check("all_p_cin", {55'd0, cout, sum}, 64'h100);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
    check("7f_plus_1", {55'd0, cout, sum}, 64'h080);
`ifdef RDA_OVERFLOW_EN
    check("ovf_7f", {63'd0, ovf}, 64'd1);
`endif

    // Start during RUN must be ignored
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("ign_sum", {55'd0, cout, sum}, 64'h046);
    check("ign_ndone", 64'(nd), 64'd1);

    // Reset in the middle of RUN aborts the operation
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_sum", {55'd0, cout, sum}, 64'h000);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_ndone", 64'(nd), 64'd0);
    check("abort_hold", {55'd0, cout, sum}, 64'h000);

    for (int i = 0; i < 2000; i++) begin
      logic [7:0] x;
      logic [7:0] y;
      logic       ci;
      x    = 8'($urandom);
      y    = 8'($urandom);
      ci   = 1'($urandom);
      exp9 = {1'b0, x} + {1'b0, y} + {8'd0, ci};
      do_op(x, y, ci, (i % 2) == 1);
      check("rand", {55'd0, cout, sum}, {55'd0, exp9});
`ifdef RDA_OVERFLOW_EN
      check("rand_ovf", {63'd0, ovf},
            {63'd0, (x[7] == y[7]) && (exp9[7] != x[7])});
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rda_iterative_adder.md
Name: rda_iterative_adder

Overview:
- Sequential recursive-doubling adder built around the carry-status star operator.
- Encodes the operand pair into per-bit kill/propagate/generate statuses and applies one prefix (doubling) round per clock.
- Decodes the resolved carry statuses into sum and carry-out.
- Serves as the multi-cycle, area-lean counterpart to the combinational doubling tree; sits behind a start/done handshake in the datapath.

Parameters:
- WIDTH, 8, operand width; power of two, >= 2.
- ROUNDS, log2(WIDTH)+1, number of doubling rounds (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- busy  output  1  high while rounds are in progress
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out

Behaviour:
- Carry-status encoding, 2 bits: kill K=00, propagate P=01, generate G=11. The code 10 is never produced.
- Star operator: x*y, where x is the more-significant status and y the less-significant.
  - Result = y if x==P, else x.
- Status vector s[0..WIDTH], with s[0] = cin ? G : K.
- For each bit, s[i+1] is:
  - G if a[i]&b[i];
  - K if ~a[i]&~b[i];
  - P otherwise.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 latches a, b and the encoded s.
  - Clears the round counter r, then goes to RUN.
  - start=0 stays in IDLE.
- RUN, edge Ek for k=1..ROUNDS, round r=k-1 with distance d=2^r:
  - For i>=d: s[i] <= s[i] * s[i-d], evaluated from pre-round values only.
  - For i<d: s[i] is unchanged.
  - After the round with r=ROUNDS-1, go to DONE.
- Entering DONE, at edge E(ROUNDS+1):
  - Carry into bit i is c[i] = s[i][1], since every position is now K or G.
  - sum[i] <= a[i]^b[i]^c[i]; cout <= s[WIDTH][1]; done <= 1.
- DONE always returns to IDLE on the next edge; done deasserts.
- Latency: done is high in the cycle following E(ROUNDS+1), i.e. 5 clocks after the start edge for WIDTH=8.
- Throughput: one operation per ROUNDS+2 clocks.
- busy = 1 in RUN and DONE; 0 in IDLE.
- start while busy is ignored; latched operands are unaffected and no request is queued.
- a, b and cin may change freely after E0.
- sum and cout hold their last result until the next DONE.
- Reset, asynchronous, effective immediately and in any state, including mid-RUN:
  - state=IDLE, r=0, s=all K, busy=0, done=0, sum=0, cout=0.
  - No done pulse is emitted for an aborted operation.
- Arithmetic: {cout,sum} == a + b + cin, with all operands unsigned WIDTH-bit.

Optional Feature:
- Macro: RDA_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - Registered with sum in DONE as c[WIDTH-1] ^ cout, i.e. two's-complement signed overflow.
  - Reset value 0; holds with sum.
- Undefined: port absent; no extra logic.

Test Plan:
- Reset, then a=8'h00, b=8'h00, cin=0, start pulse:
  - busy rises the cycle after the start edge.
  - done pulses 5 clocks after the start edge.
  - sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 (G ripples through 7 P positions) -> sum=8'h00, cout=1.
- a=8'hFF, b=8'h00, cin=1 (all-P chain, carry from cin only) -> sum=8'h00, cout=1.
- a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0; ovf=1 with RDA_OVERFLOW_EN.
- Busy and reset interaction:
  - Start 8'h12+8'h34, then pulse start with 8'hAA+8'h55 during RUN -> result 8'h46, cout=0, exactly one done.
  - Assert rst at round 2 of a new operation -> done never pulses; sum=0, cout=0, busy=0.
- 2000 random a/b/cin operations, including back-to-back starts issued the cycle after done -> {cout,sum} == a+b+cin every time.
